// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: shared mode and SR-conflict policy constants for the multi-mode flop bank
package ff_bank_pkg;
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;
    localparam int POL_RST_DOM = 0;
    localparam int POL_SET_DOM = 1;
    localparam int POL_HOLD    = 2;
endpackage

// File: rtl/ff_bit_cell.sv
// ff_bit_cell: combinational next state and SR-conflict detect for one cell
module ff_bit_cell
    import ff_bank_pkg::*;
#(
    parameter int SR_POLICY = POL_RST_DOM
) (
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    output logic       d,
    output logic       conflict
);
    logic both;
    logic sr_res;
    always_comb begin
        both     = a & b;
        sr_res   = (SR_POLICY == POL_SET_DOM) ? 1'b1 : (SR_POLICY == POL_HOLD) ? q : 1'b0;
        conflict = (mode == MODE_SR) & both;
        d        = (mode == MODE_D) ? a :
                   (mode == MODE_T) ? q ^ a :
                   both ? ((mode == MODE_JK) ? ~q : sr_res) :
                   a ? 1'b1 : b ? 1'b0 : q;
    end
endmodule

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH cells switchable between SR/JK/D/T with sticky SR-conflict logging
module multi_mode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter int               SR_POLICY = POL_RST_DOM,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] hit;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    if (SR_POLICY < POL_RST_DOM || SR_POLICY > POL_HOLD) begin : g_bad_policy
        $warning("multi_mode_ff_bank: SR_POLICY %0d out of range, treated as reset-dominant", SR_POLICY);
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_bit_cell #(.SR_POLICY(SR_POLICY)) u_cell (
            .q(q[i]),
            .a(a[i]),
            .b(b[i]),
            .mode(mode),
            .d(d[i]),
            .conflict(hit[i])
        );
    end
    assign qn = ~q;
    // clear happens before logging so a same-edge conflict survives the clear
    always_comb begin
        cnt_base = clr_err ? '0 : conflict_cnt;
        cnt_next = (en && |hit && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            q            <= RST_VAL;
            conflict     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (en) q <= d;
            conflict     <= (clr_err ? '0 : conflict) | (en ? hit : '0);
            conflict_cnt <= cnt_next;
        end
    end
endmodule
